mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of every port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width of every port.
REQ-003 SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive locked grants before forced release.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mN_req  input  1  master N (N=0 core, N=1 loader) requests one access this cycle.
REQ-008 mN_we  input  1  the request is a write when 1 and a read when 0.
REQ-009 mN_lock  input  1  master N asks to keep ownership for its next request.
REQ-010 mN_addr  input  ADDR_W  the request address.
REQ-011 mN_wdata  input  DATA_W  the write data.
REQ-012 mN_gnt  output  1  the request is accepted this cycle (combinational).
REQ-013 mN_rvalid  output  1  the read data for master N is valid this cycle.
REQ-014 mN_rdata  output  DATA_W  the read data; equals mem_rd_data, and is 0 when mN_rvalid=0.
REQ-015 mem_addr / mem_wr_ena / mem_wr_data  output  ADDR_W/1/DATA_W  the shared memory-unit port.
REQ-016 mem_rd_data  input  DATA_W  the memory-unit read data, valid 1 cycle after the address is presented.
REQ-017 gnt_cnt0 / gnt_cnt1  output  16  per-master count of accepted requests.

Function
REQ-018 SHALL issue at most one access to mem_* per cycle; mem_* SHALL be driven from the granted master's inputs combinationally.
REQ-019 SHALL keep a registered owner state with the values IDLE, OWN0 and OWN1, plus a registered 1-bit last_winner.
REQ-020 With no request: no grant, mem_wr_ena=0, mem_addr/mem_wr_data follow m0, and the next state is IDLE.
REQ-021 With only one master requesting, that master SHALL be granted in the same cycle.
REQ-022 With both masters requesting and state IDLE, or the owner not locked: grant the master != last_winner (round-robin).
REQ-023 With state OWNk, lock_run<LOCK_MAX and mk_req=1: grant k regardless of the other master's request.
REQ-024 On a grant to k with mk_lock=1, the next state SHALL be OWNk; otherwise it SHALL be IDLE. last_winner SHALL become k.
REQ-025 lock_run SHALL increment on each consecutive locked grant to the same owner and clear on release or owner change.
REQ-026 When lock_run reaches LOCK_MAX and the other master is requesting, SHALL grant the other master and clear lock_run.
REQ-027 If the owner drops mk_req while in OWNk, SHALL release ownership immediately and arbitrate normally in the same cycle.
REQ-028 For a granted read in cycle N, mk_rvalid SHALL be 1 in cycle N+1 only, with mk_rdata = mem_rd_data.
REQ-029 A granted write SHALL produce no rvalid.
REQ-030 Back-to-back reads from alternating masters SHALL each return data to the correct master on the following cycle.
REQ-031 gnt_cntN SHALL increment on each mN_gnt and saturate at 16'hFFFF.
REQ-032 mN_gnt=1 SHALL never be asserted for a master whose mN_req=0.

Reset
REQ-033 On rst: state=IDLE, last_winner=1 (so m0 wins the first tie), lock_run=0, both rvalid=0, both gnt_cnt=0.
REQ-034 A read granted in the cycle rst is asserted SHALL produce no rvalid in the following cycle.
REQ-035 While rst=1: all mN_gnt=0 and mem_wr_ena=0.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the owner-state enum (IDLE/OWN0/OWN1), the master_id_t typedef (1 bit) and the LOCK_MAX default.
REQ-037 One sub-module arb2_rr SHALL implement the combinational two-way round-robin pick; lock, counters and the read-return pipe SHALL stay in mem_bus_arbiter.

Verification
REQ-038 Reset, then both masters read (m0 addr 0x100, m1 addr 0x200) -> m0_gnt in cycle 1, m1_gnt in cycle 2; m0_rvalid in cycle 2 and m1_rvalid in cycle 3 with the matching data.
REQ-039 m1 locked writes held for 12 cycles while m0_req=1 -> m1 granted 8 consecutive cycles, then m0 granted in cycle 9.
REQ-040 Only m0 writes 0xDEADBEEF to 0x300 -> same-cycle m0_gnt, mem_wr_ena=1 and mem_addr=0x300; no rvalid follows.
REQ-041 Read granted, rst asserted the same cycle -> no rvalid next cycle; gnt_cnt0=0.
REQ-042 Preload gnt_cnt0=16'hFFFE, then 3 m0 grants -> gnt_cnt0=16'hFFFF and it holds.
REQ-043 Owner in OWN0 drops m0_req while m1_req=1 -> m1_gnt in the same cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory bus arbiter: owner state,
// master identifier and the default lock-run ceiling.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  typedef logic master_id_t;

  localparam int LOCK_MAX_DEFAULT = 8;

endpackage

// File: rtl/arb2_rr.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the master that did not win last.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_t last_winner,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = req0 && (!req1 || (last_winner == 1'b1));
    gnt1 = req1 && (!req0 || (last_winner == 1'b0));
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (core, loader) arbiter for one shared memory port with
// bounded ownership locking, grant counters and a one-cycle read return.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_ena,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
);

  localparam int RUN_W = $clog2(LOCK_MAX + 1);

  own_state_t       state_q, state_d;
  master_id_t       last_winner_q;
  logic [RUN_W-1:0] lock_run_q, lock_run_d;
  logic [1:0]       rd_vld_p1;
  logic             rr_gnt0, rr_gnt1;
  logic             hold_owner, any_gnt, win_lock;
  master_id_t       win_id;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  arb2_rr u_rr (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_winner (last_winner_q),
    .gnt0        (rr_gnt0),
    .gnt1        (rr_gnt1)
  );

  // Grant selection: a locked owner still requesting keeps the bus until its
  // run hits LOCK_MAX; at the ceiling round-robin hands a tie to the other side.
  always_comb begin
    hold_owner = (((state_q == OWN0) && m0_req) || ((state_q == OWN1) && m1_req))
                 && (lock_run_q < RUN_W'(LOCK_MAX));
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end else if (hold_owner) begin
      m0_gnt = (state_q == OWN0);
      m1_gnt = (state_q == OWN1);
    end else begin
      m0_gnt = rr_gnt0;
      m1_gnt = rr_gnt1;
    end
    any_gnt  = m0_gnt || m1_gnt;
    win_id   = m1_gnt;
    win_lock = m1_gnt ? m1_lock : m0_lock;
  end

  always_comb begin
    state_d    = IDLE;
    lock_run_d = '0;
    if (any_gnt && win_lock) begin
      state_d = win_id ? OWN1 : OWN0;
      if (state_q == state_d)
        lock_run_d = (lock_run_q < RUN_W'(LOCK_MAX)) ? lock_run_q + RUN_W'(1) : lock_run_q;
      else
        lock_run_d = RUN_W'(1);
    end
  end

  always_comb begin
    mem_addr    = m1_gnt ? m1_addr : m0_addr;
    mem_wr_data = m1_gnt ? m1_wdata : m0_wdata;
    mem_wr_ena  = (m0_gnt && m0_we) || (m1_gnt && m1_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      lock_run_q    <= '0;
      rd_vld_p1     <= '0;
      gnt_cnt0      <= '0;
      gnt_cnt1      <= '0;
    end else begin
      state_q    <= state_d;
      lock_run_q <= lock_run_d;
      if (any_gnt)
        last_winner_q <= win_id;
      rd_vld_p1 <= {m1_gnt && !m1_we, m0_gnt && !m0_we};
      if (m0_gnt)
        gnt_cnt0 <= sat_inc16(gnt_cnt0);
      if (m1_gnt)
        gnt_cnt1 <= sat_inc16(gnt_cnt1);
    end
  end

  // p1: read data returns one cycle after the granted address
  assign m0_rvalid = rd_vld_p1[0];
  assign m1_rvalid = rd_vld_p1[1];
  assign m0_rdata  = rd_vld_p1[0] ? mem_rd_data : '0;
  assign m1_rdata  = rd_vld_p1[1] ? mem_rd_data : '0;

endmodule
